// File: rtl/mem_target_pkg.sv
// Shared constants for the CPU <-> memory-target link: command codes, address map and target states.
package cpu_mem_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam int         RAM_WORDS = 256;
    localparam logic [8:0] LED_ADDR  = 9'h100;
    localparam logic [8:0] SW_ADDR   = 9'h140;

    typedef enum logic {
        INIT,
        RUN
    } mem_state_e;

endpackage

// File: rtl/mem_target_if.sv
// CPU-side memory bus: the CPU drives command/address/data, the target returns read data and readiness.
interface mem_target_if;

    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        ready;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output ready
    );

endinterface

// File: rtl/mem_target_ram_sp.sv
// Single-port RAM: synchronous write, synchronous read with a read-enable so dout holds between reads.
module ram_sp #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dout_q;

    // Array has no reset so it maps onto block RAM; the owner clears it explicitly.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else if (re) begin
            dout_q <= mem_q[addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/mem_target.sv
// Memory-mapped target: 256x16 RAM, LED register and synchronised switch port, with a post-reset RAM clear.
// Optional MEM_ACCESS_CNT_EN adds rd_count/wr_count counters of successful RUN-state accesses.
module mem_target
    import cpu_mem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mem_target_if.slave  bus,
    input  logic [7:0]   SW,
    output logic [7:0]   LEDR,
    output logic         bus_err
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
`endif
);

    mem_state_e  state_q, state_d;
    logic [7:0]  clrAddr_q, clrAddr_d;
    logic [7:0]  swMeta_q, swSync_q;
    logic [7:0]  ledr_q;
    logic        busErr_q;
    logic        rdSel_q;
    logic [15:0] rdReg_q;

    logic        isRam, isLed, isSw;
    logic        cmdRead, cmdWrite, cmdIll;
    logic        readOk, writeOk, accessErr;
    logic        ramWe, ramRe;
    logic [7:0]  ramAddr;
    logic [15:0] ramDin, ramDout;
    logic [15:0] regRdData;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            clrAddr_q <= '0;
        end else begin
            state_q   <= state_d;
            clrAddr_q <= clrAddr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clrAddr_d = clrAddr_q;
        if (state_q == INIT) begin
            clrAddr_d = clrAddr_q + 8'd1;
            if (clrAddr_q == 8'hFF) begin
                state_d = RUN;
            end
        end
    end

    // Address decode; only meaningful in RUN, INIT traffic is masked below.
    always_comb begin
        isRam     = ~bus.mem_addr[8];
        isLed     = (bus.mem_addr == LED_ADDR);
        isSw      = (bus.mem_addr == SW_ADDR);
        cmdRead   = (bus.mem_cmd == MREAD);
        cmdWrite  = (bus.mem_cmd == MWRITE);
        cmdIll    = (bus.mem_cmd == 2'b11);
        readOk    = cmdRead  && (isRam || isLed || isSw);
        writeOk   = cmdWrite && (isRam || isLed);
        accessErr = (cmdRead && !readOk) || (cmdWrite && !writeOk) || cmdIll;
    end

    always_comb begin
        ramWe   = 1'b0;
        ramRe   = 1'b0;
        ramAddr = bus.mem_addr[7:0];
        ramDin  = bus.write_data;
        case (state_q)
            INIT: begin
                ramWe   = 1'b1;
                ramAddr = clrAddr_q;
                ramDin  = '0;
            end
            RUN: begin
                ramWe = writeOk && isRam;
                ramRe = readOk && isRam;
            end
            default: ;
        endcase
    end

    always_comb begin
        regRdData = '0;
        if (readOk && isLed) begin
            regRdData = {8'b0, ledr_q};
        end else if (readOk && isSw) begin
            regRdData = {8'b0, swSync_q};
        end
    end

    // Register-side read data and the RAM/register select are captured together so read_data stays registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            swMeta_q <= '0;
            swSync_q <= '0;
            ledr_q   <= '0;
            busErr_q <= 1'b0;
            rdSel_q  <= 1'b0;
            rdReg_q  <= '0;
        end else begin
            swMeta_q <= SW;
            swSync_q <= swMeta_q;
            if (state_q == RUN) begin
                if (accessErr) begin
                    busErr_q <= 1'b1;
                end
                if (writeOk && isLed) begin
                    ledr_q <= bus.write_data[7:0];
                end
                if (cmdRead) begin
                    rdSel_q <= readOk && isRam;
                    rdReg_q <= regRdData;
                end
            end
        end
    end

`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] rdCount_q, wrCount_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdCount_q <= '0;
            wrCount_q <= '0;
        end else if (state_q == RUN) begin
            if (readOk) begin
                rdCount_q <= rdCount_q + 16'd1;
            end
            if (writeOk) begin
                wrCount_q <= wrCount_q + 16'd1;
            end
        end
    end

    assign rd_count = rdCount_q;
    assign wr_count = wrCount_q;
`endif

    ram_sp #(
        .WIDTH (16),
        .DEPTH (RAM_WORDS)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ramWe),
        .re    (ramRe),
        .addr  (ramAddr),
        .din   (ramDin),
        .dout  (ramDout)
    );

    assign bus.read_data = rdSel_q ? ramDout : rdReg_q;
    assign bus.ready     = (state_q == RUN);
    assign LEDR          = ledr_q;
    assign bus_err       = busErr_q;

endmodule

// File: tb/tb_mem_target.sv
// Scoreboard bench for mem_target: reads push expected data, a monitor compares one cycle after each RUN-state read.
module tb_mem_target;
    import cpu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  sw = 8'h00;
    logic [7:0]  ledr;
    logic        busErr;
`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] rdCount, wrCount;
`endif

    mem_target_if bus();

    mem_target dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .SW       (sw),
        .LEDR     (ledr),
        .bus_err  (busErr)
`ifdef MEM_ACCESS_CNT_EN
        ,
        .rd_count (rdCount),
        .wr_count (wrCount)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cycles;
    logic [15:0] expQ[$];
    string       nameQ[$];
    logic        rdValid = 1'b0;
    logic [15:0] monExp;
    string       monName;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input logic [8:0] addr,
                                 input logic [15:0] data, input logic [15:0] expRd, input string name);
        @(negedge clk);
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = data;
        if (cmd == MREAD && bus.ready) begin
            expQ.push_back(expRd);
            nameQ.push_back(name);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset        = 1'b1;
        bus.mem_cmd  = MNONE;
        @(negedge clk);
        reset        = 1'b0;
    endtask

    // Holds the given command on the bus through INIT and counts edges until ready rises.
    task automatic waitReady(input logic [1:0] cmd, input logic [8:0] addr,
                             input logic [15:0] data, output int n);
        n              = 0;
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = data;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ready) break;
        end
        bus.mem_cmd = MNONE;
    endtask

    always @(posedge clk) rdValid <= !reset && bus.ready && (bus.mem_cmd == MREAD);

    always @(negedge clk) begin
        if (rdValid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedRead actual=%h expected=none", bus.read_data);
            end else begin
                monExp  = expQ.pop_front();
                monName = nameQ.pop_front();
                checkOutput(monName, bus.read_data, monExp);
            end
        end
    end

    initial begin
        bus.mem_cmd    = MNONE;
        bus.mem_addr   = '0;
        bus.write_data = '0;

        doReset();
        checkOutput("resetReady", {15'b0, bus.ready}, 16'h0000);
        checkOutput("resetReadData", bus.read_data, 16'h0000);
        checkOutput("resetLedr", {8'b0, ledr}, 16'h0000);
        checkOutput("resetBusErr", {15'b0, busErr}, 16'h0000);
        waitReady(MREAD, 9'h0A5, 16'h0000, cycles);
        checkOutput("readyLatency", cycles[15:0], 16'd256);
        checkOutput("initReadIgnored", bus.read_data, 16'h0000);

        applyStimulus(MREAD, 9'h0A5, 16'h0000, 16'h0000, "readCleared0A5");

        applyStimulus(MWRITE, 9'h012, 16'hBEEF, 16'h0000, "");
        applyStimulus(MREAD, 9'h012, 16'h0000, 16'hBEEF, "readBack012");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000, "");
            checkOutput("holdBEEF", bus.read_data, 16'hBEEF);
        end

        applyStimulus(MWRITE, LED_ADDR, 16'h12C3, 16'h0000, "");
        applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000, "");
        checkOutput("ledWrite", {8'b0, ledr}, 16'h00C3);
        applyStimulus(MREAD, LED_ADDR, 16'h0000, 16'h00C3, "readLed");

        // Switch change lands in the same cycle as the first read; the third read sees it.
        applyStimulus(MREAD, SW_ADDR, 16'h0000, 16'h0000, "swRead1");
        sw = 8'h5A;
        applyStimulus(MREAD, SW_ADDR, 16'h0000, 16'h0000, "swRead2");
        applyStimulus(MREAD, SW_ADDR, 16'h0000, 16'h005A, "swRead3");
        applyStimulus(MREAD, SW_ADDR, 16'h0000, 16'h005A, "swRead4");
        applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000, "");
        checkOutput("busErrClean", {15'b0, busErr}, 16'h0000);

        applyStimulus(MREAD, 9'h1FF, 16'h0000, 16'h0000, "readUnmapped");
        applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000, "");
        checkOutput("busErrSet", {15'b0, busErr}, 16'h0001);
        applyStimulus(MWRITE, SW_ADDR, 16'hFFFF, 16'h0000, "");
        applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000, "");
        checkOutput("swWriteLedr", {8'b0, ledr}, 16'h00C3);
        applyStimulus(MREAD, SW_ADDR, 16'h0000, 16'h005A, "swAfterWrite");
        applyStimulus(2'b11, 9'h012, 16'h0000, 16'h0000, "");
        applyStimulus(2'b11, LED_ADDR, 16'h0055, 16'h0000, "");
        applyStimulus(MREAD, 9'h012, 16'h0000, 16'hBEEF, "illegalRamKept");
        applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000, "");
        checkOutput("illegalLedr", {8'b0, ledr}, 16'h00C3);
        checkOutput("busErrSticky", {15'b0, busErr}, 16'h0001);
`ifdef MEM_ACCESS_CNT_EN
        checkOutput("rdCount", rdCount, 16'd9);
        checkOutput("wrCount", wrCount, 16'd2);
`endif

        applyStimulus(MWRITE, 9'h010, 16'h1234, 16'h0000, "");
        applyStimulus(MREAD, 9'h010, 16'h0000, 16'h1234, "readBack010");
        applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000, "");

        doReset();
        for (int i = 0; i < 100; i++) begin
            case (i % 3)
                0:       begin bus.mem_cmd = MWRITE; bus.mem_addr = 9'h020; bus.write_data = 16'hAAAA; end
                1:       begin bus.mem_cmd = MWRITE; bus.mem_addr = LED_ADDR; bus.write_data = 16'h00FF; end
                default: begin bus.mem_cmd = MREAD;  bus.mem_addr = 9'h010; bus.write_data = 16'h0000; end
            endcase
            @(negedge clk);
        end
        checkOutput("midInitReady", {15'b0, bus.ready}, 16'h0000);
        checkOutput("midInitReadData", bus.read_data, 16'h0000);
        checkOutput("midInitLedr", {8'b0, ledr}, 16'h0000);

        doReset();
        waitReady(MWRITE, 9'h030, 16'h7777, cycles);
        checkOutput("rereadyLatency", cycles[15:0], 16'd256);
        checkOutput("rearmLedr", {8'b0, ledr}, 16'h0000);
        checkOutput("rearmBusErr", {15'b0, busErr}, 16'h0000);
`ifdef MEM_ACCESS_CNT_EN
        checkOutput("rdCountReset", rdCount, 16'd0);
        checkOutput("wrCountReset", wrCount, 16'd0);
`endif
        applyStimulus(MREAD, 9'h010, 16'h0000, 16'h0000, "reclear010");
        applyStimulus(MREAD, 9'h020, 16'h0000, 16'h0000, "initWrite020");
        applyStimulus(MREAD, 9'h030, 16'h0000, 16'h0000, "initWrite030");
        applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000, "");
        applyStimulus(MNONE, 9'h000, 16'h0000, 16'h0000, "");
        checkOutput("queueDrained", expQ.size() > 0 ? 16'h0001 : 16'h0000, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
